// File: rtl/video_fetch.sv
// Screen RAM arbiter: fetches a bitmap/attribute byte pair for the video stage on every
// bitmap address change and serves CPU reads/writes in the remaining RAM cycles.
module video_fetch #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [AW-1:0] vid_addr,
    input  logic [AW-1:0] vid_attr_addr,
    output logic [DW-1:0] vid_data,
    output logic [DW-1:0] vid_attr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        V_PIX,
        V_ATTR,
        V_COMMIT,
        C_ACC,
        C_CAP,
        C_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] tag_q, tag_d;
    logic          tag_valid_q, tag_valid_d;
    logic [AW-1:0] attr_addr_q, attr_addr_d;
    logic [DW-1:0] pix_buf_q, pix_buf_d;
    logic [DW-1:0] vid_data_q, vid_data_d;
    logic [DW-1:0] vid_attr_q, vid_attr_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          fetch_needed;

    // A fetch in flight always finishes with its own tag; a newer address is caught back in IDLE.
    assign fetch_needed = !tag_valid_q || (vid_addr != tag_q);

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        attr_addr_d = attr_addr_q;
        pix_buf_d   = pix_buf_q;
        vid_data_d  = vid_data_q;
        vid_attr_d  = vid_attr_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = cpu_ack_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (fetch_needed) begin
                    tag_d       = vid_addr;
                    tag_valid_d = 1'b1;
                    attr_addr_d = vid_attr_addr;
                    ram_addr_d  = vid_addr;
                    ram_we_d    = 1'b0;
                    state_d     = V_PIX;
                end else if (cpu_req && !cpu_ack_q) begin
                    ram_addr_d  = cpu_addr;
                    ram_we_d    = cpu_we;
                    ram_wdata_d = cpu_wdata;
                    state_d     = C_ACC;
                end
            end
            V_PIX: begin
                ram_addr_d = attr_addr_q;
                state_d    = V_ATTR;
            end
            V_ATTR: begin
                pix_buf_d = ram_rdata;
                state_d   = V_COMMIT;
            end
            // Bitmap and attribute land on the same edge so the video stage never sees a mixed pair.
            V_COMMIT: begin
                vid_data_d = pix_buf_q;
                vid_attr_d = ram_rdata;
                state_d    = IDLE;
            end
            C_ACC: begin
                ram_we_d = 1'b0;
                state_d  = C_CAP;
            end
            C_CAP: begin
                cpu_rdata_d = ram_rdata;
                cpu_ack_d   = 1'b1;
                state_d     = C_DONE;
            end
            C_DONE: begin
                cpu_ack_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            attr_addr_q <= '0;
            pix_buf_q   <= '0;
            vid_data_q  <= '0;
            vid_attr_q  <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            attr_addr_q <= attr_addr_d;
            pix_buf_q   <= pix_buf_d;
            vid_data_q  <= vid_data_d;
            vid_attr_q  <= vid_attr_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_attr  = vid_attr_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: synchronous RAM model plus a shadow memory holding the expected contents.
module tb_video_fetch;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic [12:0] vid_addr, vid_attr_addr, cpu_addr;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  vid_data, vid_attr, cpu_rdata, ram_wdata, ram_rdata;
    logic        cpu_ack, ram_we;
    logic [12:0] ram_addr;

    logic [7:0]  mem     [0:8191];
    logic [7:0]  ref_mem [0:8191];
    logic        bd_we;
    logic [12:0] bd_addr;
    logic [7:0]  bd_data;
    logic [15:0] shown;
    int          n_cmp, n_err;

    video_fetch #(.AW(13), .DW(8)) dut (
        .clk(clk), .n_reset(n_reset),
        .vid_addr(vid_addr), .vid_attr_addr(vid_attr_addr),
        .vid_data(vid_data), .vid_attr(vid_attr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM; the backdoor port preloads contents while the DUT is not writing.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [12:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        step();
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic logic [12:0] new_bitmap_addr(input logic [12:0] cur);
        return 13'((int'(cur) + 1 + int'($urandom_range(0, 6142))) % 6144);
    endfunction

    task automatic test_reset();
        #2 n_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vid_addr = 13'($urandom); vid_attr_addr = 13'($urandom);
            cpu_req = 1'($urandom); cpu_we = 1'($urandom);
            cpu_addr = 13'($urandom); cpu_wdata = 8'($urandom);
            step();
            n_cmp++;
            if ({vid_data, vid_attr, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata} !== 47'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h, expected 0",
                         {vid_data, vid_attr, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata});
            end
        end
        bd_write(13'h0100, 8'hC3);
        bd_write(13'h1820, 8'h1E);
        vid_addr = 13'h0100; vid_attr_addr = 13'h1820; cpu_req = 1'b0; cpu_we = 1'b0;
        n_reset = 1'b1;
        step();
        n_cmp++;
        if ({ram_addr, ram_we} !== {13'h0100, 1'b0}) begin
            n_err++;
            $display("FAIL reset_fetch_start: got %h, expected %h", {ram_addr, ram_we}, {13'h0100, 1'b0});
        end
        step(); step();
        n_cmp++;
        if ({vid_data, vid_attr} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_hold: got %h, expected 0000", {vid_data, vid_attr});
        end
        step();
        n_cmp++;
        if ({vid_data, vid_attr} !== 16'hC31E) begin
            n_err++;
            $display("FAIL reset_first_fetch: got %h, expected c31e", {vid_data, vid_attr});
        end
        shown = {vid_data, vid_attr};
        shown = 16'hC31E;
    endtask

    task automatic test_video_fetch();
        for (int it = 0; it < 6; it++) begin
            logic [12:0] a, at;
            logic [15:0] exp_new;
            if (it == 0) begin
                a = 13'h0000; at = 13'h1800;
                bd_write(a, 8'hAA); bd_write(at, 8'h47);
            end else begin
                a  = new_bitmap_addr(vid_addr);
                at = 13'(6144 + $urandom_range(0, 767));
                bd_write(a, 8'($urandom)); bd_write(at, 8'($urandom));
            end
            exp_new = {ref_mem[a], ref_mem[at]};
            vid_addr = a; vid_attr_addr = at;
            for (int k = 1; k <= 4; k++) begin
                step();
                n_cmp++;
                if ({vid_data, vid_attr} !== ((k < 4) ? shown : exp_new)) begin
                    n_err++;
                    $display("FAIL video_fetch it%0d T+%0d: got %h, expected %h", it, k,
                             {vid_data, vid_attr}, (k < 4) ? shown : exp_new);
                end
            end
            shown = exp_new;
            repeat (4) step();
        end
    endtask

    task automatic test_cpu_write_read();
        for (int it = 0; it < 4; it++) begin
            logic [12:0] a;
            logic [7:0]  d;
            a = (it == 0) ? 13'h0123 : 13'($urandom_range(0, 6911));
            d = (it == 0) ? 8'h5A : 8'($urandom);
            cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_req = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                step();
                n_cmp++;
                if ({cpu_ack, ram_we} !== {1'(k == 3), 1'(k == 1)}) begin
                    n_err++;
                    $display("FAIL cpu_write it%0d T+%0d ack/we: got %b, expected %b", it, k,
                             {cpu_ack, ram_we}, {1'(k == 3), 1'(k == 1)});
                end
                if (k == 1) begin
                    n_cmp++;
                    if ({ram_addr, ram_wdata} !== {a, d}) begin
                        n_err++;
                        $display("FAIL cpu_write_bus it%0d: got %h, expected %h", it,
                                 {ram_addr, ram_wdata}, {a, d});
                    end
                end
            end
            cpu_req = 1'b0; ref_mem[a] = d;
            step();
            cpu_addr = a; cpu_we = 1'b0; cpu_wdata = 8'($urandom); cpu_req = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                step();
                n_cmp++;
                if ({cpu_ack, ram_we} !== {1'(k == 3), 1'b0}) begin
                    n_err++;
                    $display("FAIL cpu_read it%0d T+%0d ack/we: got %b, expected %b", it, k,
                             {cpu_ack, ram_we}, {1'(k == 3), 1'b0});
                end
            end
            n_cmp++;
            if (cpu_rdata !== ref_mem[a]) begin
                n_err++;
                $display("FAIL cpu_read_data it%0d: got %h, expected %h", it, cpu_rdata, ref_mem[a]);
            end
            cpu_req = 1'b0;
            step();
        end
    endtask

    task automatic test_collision();
        for (int it = 0; it < 3; it++) begin
            logic [12:0] a, at, c;
            logic [15:0] exp_new;
            logic [7:0]  exp_c;
            a  = new_bitmap_addr(vid_addr);
            at = 13'(6144 + $urandom_range(0, 767));
            c  = 13'($urandom_range(0, 6911));
            bd_write(a, 8'($urandom)); bd_write(at, 8'($urandom)); bd_write(c, 8'($urandom));
            exp_new = {ref_mem[a], ref_mem[at]};
            exp_c   = ref_mem[c];
            vid_addr = a; vid_attr_addr = at;
            cpu_addr = c; cpu_we = 1'b0; cpu_req = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                step();
                if (k == 3 || k == 4) begin
                    n_cmp++;
                    if ({vid_data, vid_attr} !== ((k == 3) ? shown : exp_new)) begin
                        n_err++;
                        $display("FAIL collision_video it%0d T+%0d: got %h, expected %h", it, k,
                                 {vid_data, vid_attr}, (k == 3) ? shown : exp_new);
                    end
                end
                n_cmp++;
                if (cpu_ack !== 1'(k == 7)) begin
                    n_err++;
                    $display("FAIL collision_ack it%0d T+%0d: got %b, expected %b", it, k, cpu_ack, 1'(k == 7));
                end
            end
            n_cmp++;
            if (cpu_rdata !== exp_c) begin
                n_err++;
                $display("FAIL collision_rdata it%0d: got %h, expected %h", it, cpu_rdata, exp_c);
            end
            shown = exp_new;
            cpu_req = 1'b0;
            repeat (5) step();
        end
    endtask

    task automatic test_mid_fetch();
        for (int it = 0; it < 3; it++) begin
            logic [12:0] a0, a1, b0, b1;
            logic [7:0]  d0, e0;
            logic [15:0] new0, new1, exp_v;
            if (it == 0) begin
                bd_write(13'h0200, 8'h11); bd_write(13'h1900, 8'h22);
                vid_addr = 13'h0200; vid_attr_addr = 13'h1900;
                repeat (6) step();
                n_cmp++;
                if ({vid_data, vid_attr} !== 16'h1122) begin
                    n_err++;
                    $display("FAIL mid_fetch_park: got %h, expected 1122", {vid_data, vid_attr});
                end
                shown = 16'h1122;
                a0 = 13'h0000; a1 = 13'h0001; b0 = 13'h1800; b1 = 13'h1801;
            end else begin
                a0 = new_bitmap_addr(vid_addr);
                a1 = new_bitmap_addr(a0);
                b0 = 13'(6144 + $urandom_range(0, 767));
                b1 = 13'(6144 + ((int'(b0) - 6144 + 1 + int'($urandom_range(0, 766))) % 768));
            end
            d0 = 8'($urandom); e0 = 8'($urandom);
            bd_write(a0, d0); bd_write(b0, e0); bd_write(a1, ~d0); bd_write(b1, ~e0);
            new0 = {ref_mem[a0], ref_mem[b0]};
            new1 = {ref_mem[a1], ref_mem[b1]};
            vid_addr = a0; vid_attr_addr = b0;
            step();
            vid_addr = a1; vid_attr_addr = b1;
            for (int k = 2; k <= 8; k++) begin
                step();
                exp_v = (k < 4) ? shown : ((k < 8) ? new0 : new1);
                n_cmp++;
                if ({vid_data, vid_attr} !== exp_v) begin
                    n_err++;
                    $display("FAIL mid_fetch it%0d T+%0d: got %h, expected %h", it, k, {vid_data, vid_attr}, exp_v);
                end
            end
            shown = new1;
            repeat (4) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] ba [3];
        logic [7:0]  bdat [3];
        int n;
        for (int i = 0; i < 3; i++) begin
            ba[i] = 13'($urandom_range(0, 6911));
            bdat[i] = 8'($urandom);
        end
        cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_we    = (i < 3);
            cpu_addr  = ba[i % 3];
            cpu_wdata = (i < 3) ? bdat[i] : 8'($urandom);
            n = (i == 0) ? 3 : 4;
            for (int k = 1; k <= n; k++) begin
                step();
                n_cmp++;
                if ({cpu_ack, ram_we} !== {1'(k == n), 1'((i < 3) && (k == n - 2))}) begin
                    n_err++;
                    $display("FAIL b2b acc%0d cyc%0d ack/we: got %b, expected %b", i, k,
                             {cpu_ack, ram_we}, {1'(k == n), 1'((i < 3) && (k == n - 2))});
                end
            end
            if (i < 3) begin
                ref_mem[ba[i]] = bdat[i];
            end else begin
                n_cmp++;
                if (cpu_rdata !== ref_mem[ba[i - 3]]) begin
                    n_err++;
                    $display("FAIL b2b_rdata acc%0d: got %h, expected %h", i, cpu_rdata, ref_mem[ba[i - 3]]);
                end
            end
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [12:0] a;
        logic [15:0] exp_v;
        a = 13'($urandom_range(0, 6911));
        bd_write(a, 8'h3C);
        cpu_addr = a; cpu_wdata = 8'hC3; cpu_we = 1'b1; cpu_req = 1'b1;
        step();
        n_cmp++;
        if (ram_we !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_strobe_before: got %b, expected 1", ram_we);
        end
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({vid_data, vid_attr, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata} !== 47'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %h, expected 0",
                     {vid_data, vid_attr, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata});
        end
        cpu_req = 1'b0;
        step(); step();
        n_reset = 1'b1;
        exp_v = {ref_mem[vid_addr], ref_mem[vid_attr_addr]};
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                n_cmp++;
                if (ram_addr !== vid_addr) begin
                    n_err++;
                    $display("FAIL rst_mid_refetch: got %h, expected %h", ram_addr, vid_addr);
                end
            end
            n_cmp++;
            if ({cpu_ack, ram_we} !== 2'b00) begin
                n_err++;
                $display("FAIL rst_mid_quiet cyc%0d: got %b, expected 00", k, {cpu_ack, ram_we});
            end
            if (k == 4) begin
                n_cmp++;
                if ({vid_data, vid_attr} !== exp_v) begin
                    n_err++;
                    $display("FAIL rst_mid_video: got %h, expected %h", {vid_data, vid_attr}, exp_v);
                end
            end
        end
        shown = exp_v;
        cpu_addr = a; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h3C}) begin
            n_err++;
            $display("FAIL rst_mid_no_write: got %h, expected %h", {cpu_ack, cpu_rdata}, {1'b1, 8'h3C});
        end
        cpu_req = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; shown = 16'h0000;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        vid_addr = '0; vid_attr_addr = '0; cpu_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        test_reset();
        test_video_fetch();
        test_cpu_write_read();
        test_collision();
        test_mid_fetch();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
